// File: rtl/firmware_image_reader_pkg.sv
// Shared types and constants for the firmware image reader.
// Holds FSM states, error codes, header layout offsets and the default magic.
package firmware_image_reader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR_MAGIC,
        HDR_SIZE,
        HDR_SIG,
        STREAM,
        DONE,
        ERROR
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_MAGIC   = 2'd1,
        ERR_SIZE    = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_e;

    localparam logic [31:0] OFF_MAGIC   = 32'd0;
    localparam logic [31:0] OFF_SIZE    = 32'd4;
    localparam logic [31:0] OFF_SIG     = 32'd8;
    localparam logic [31:0] OFF_PAYLOAD = 32'd40;

    localparam logic [31:0] FW_IMG_MAGIC = 32'h5346_5047;

endpackage

// File: rtl/firmware_image_reader.sv
// Firmware image reader: fetches header, signature and payload one word at a time.
// Optional read-response timeout is enabled with `define FETCH_TIMEOUT_EN.
module firmware_image_reader
    import firmware_image_reader_pkg::*;
#(
    parameter logic [31:0] MAX_FW_BYTES   = 32'h0010_0000,
    parameter logic [31:0] IMG_MAGIC      = FW_IMG_MAGIC,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [31:0]  base_addr,
    output logic         mem_req,
    output logic [31:0]  mem_addr,
    input  logic [31:0]  mem_rdata,
    input  logic         mem_rvalid,
    output logic [255:0] signature,
    output logic         signature_valid,
    output logic [31:0]  firmware_size,
    output logic [31:0]  firmware_addr,
    output logic [31:0]  firmware_data,
    output logic         firmware_data_valid,
    input  logic         firmware_ready,
    output logic         done,
    output logic         error,
    output logic [1:0]   err_code
);

    state_e        r_state, w_state;
    logic          r_mem_req, w_mem_req;
    logic [31:0]   r_mem_addr, w_mem_addr;
    logic          r_busy, w_busy;
    logic [31:0]   r_base, w_base;
    logic [31:0]   r_size, w_size;
    logic [2:0]    r_cnt, w_cnt;
    logic [255:0]  r_sig, w_sig;
    logic          r_sig_valid, w_sig_valid;
    logic [31:0]   r_off, w_off;
    logic [31:0]   r_data, w_data;
    logic          r_dvalid, w_dvalid;
    logic          r_done, w_done;
    logic          r_error, w_error;
    err_e          r_err, w_err;
    logic          w_rsp;
    logic          w_size_bad;
    logic          w_tmo_hit;

    // A response only counts while our single read is outstanding
    assign w_rsp = r_busy && mem_rvalid;

    assign w_size_bad = (mem_rdata == 32'd0)
                     || (mem_rdata > MAX_FW_BYTES)
                     || (mem_rdata[1:0] != 2'b00);

`ifdef FETCH_TIMEOUT_EN
    logic [31:0] r_tmo;

    // Count cycles since the last request while waiting for its response
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tmo <= 32'd0;
        end else if (w_mem_req || !r_busy) begin
            r_tmo <= 32'd0;
        end else begin
            r_tmo <= r_tmo + 32'd1;
        end
    end

    assign w_tmo_hit = r_busy && !mem_rvalid
                    && (r_tmo == 32'(TIMEOUT_CYCLES - 1));
`else
    assign w_tmo_hit = 1'b0;
`endif

    // Next-state and next-output logic for the fetch sequence
    always_comb begin
        w_state     = r_state;
        w_mem_req   = 1'b0;
        w_mem_addr  = r_mem_addr;
        w_busy      = r_busy;
        w_base      = r_base;
        w_size      = r_size;
        w_cnt       = r_cnt;
        w_sig       = r_sig;
        w_sig_valid = r_sig_valid;
        w_off       = r_off;
        w_data      = r_data;
        w_dvalid    = r_dvalid;
        w_done      = r_done;
        w_error     = r_error;
        w_err       = r_err;

        if (w_rsp) begin
            w_busy = 1'b0;
        end

        unique case (r_state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    w_state     = HDR_MAGIC;
                    w_base      = base_addr;
                    w_mem_req   = 1'b1;
                    w_mem_addr  = base_addr + OFF_MAGIC;
                    w_busy      = 1'b1;
                    w_cnt       = 3'd0;
                    w_off       = 32'd0;
                    w_dvalid    = 1'b0;
                    w_sig_valid = 1'b0;
                    w_done      = 1'b0;
                    w_error     = 1'b0;
                    w_err       = ERR_NONE;
                end
            end
            HDR_MAGIC: begin
                if (w_rsp) begin
                    if (mem_rdata != IMG_MAGIC) begin
                        w_state = ERROR;
                        w_error = 1'b1;
                        w_err   = ERR_MAGIC;
                    end else begin
                        w_state    = HDR_SIZE;
                        w_mem_req  = 1'b1;
                        w_mem_addr = r_base + OFF_SIZE;
                        w_busy     = 1'b1;
                    end
                end
            end
            HDR_SIZE: begin
                if (w_rsp) begin
                    if (w_size_bad) begin
                        w_state = ERROR;
                        w_error = 1'b1;
                        w_err   = ERR_SIZE;
                    end else begin
                        w_state    = HDR_SIG;
                        w_size     = mem_rdata;
                        w_cnt      = 3'd0;
                        w_mem_req  = 1'b1;
                        w_mem_addr = r_base + OFF_SIG;
                        w_busy     = 1'b1;
                    end
                end
            end
            HDR_SIG: begin
                if (w_rsp) begin
                    // Shift in: after eight words, word 0 sits at the top
                    w_sig = {r_sig[223:0], mem_rdata};
                    w_cnt = r_cnt + 3'd1;
                    w_mem_req = 1'b1;
                    w_busy    = 1'b1;
                    if (r_cnt == 3'd7) begin
                        w_state     = STREAM;
                        w_sig_valid = 1'b1;
                        w_off       = 32'd0;
                        w_mem_addr  = r_base + OFF_PAYLOAD;
                    end else begin
                        w_mem_addr = r_base + OFF_SIG
                                   + {27'd0, w_cnt, 2'b00};
                    end
                end
            end
            STREAM: begin
                if (w_rsp) begin
                    w_data   = mem_rdata;
                    w_dvalid = 1'b1;
                end else if (r_dvalid && firmware_ready) begin
                    w_dvalid = 1'b0;
                    if (r_off == r_size - 32'd4) begin
                        w_state = DONE;
                        w_done  = 1'b1;
                    end else begin
                        w_off      = r_off + 32'd4;
                        w_mem_req  = 1'b1;
                        w_mem_addr = r_base + OFF_PAYLOAD + r_off + 32'd4;
                        w_busy     = 1'b1;
                    end
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase

        if (w_tmo_hit) begin
            w_state   = ERROR;
            w_error   = 1'b1;
            w_err     = ERR_TIMEOUT;
            w_busy    = 1'b0;
            w_mem_req = 1'b0;
            w_dvalid  = 1'b0;
        end
    end

    // State and output registers; reset clears everything to zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_busy      <= 1'b0;
            r_base      <= 32'd0;
            r_size      <= 32'd0;
            r_cnt       <= 3'd0;
            r_sig       <= 256'd0;
            r_sig_valid <= 1'b0;
            r_off       <= 32'd0;
            r_data      <= 32'd0;
            r_dvalid    <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err       <= ERR_NONE;
        end else begin
            r_state     <= w_state;
            r_mem_req   <= w_mem_req;
            r_mem_addr  <= w_mem_addr;
            r_busy      <= w_busy;
            r_base      <= w_base;
            r_size      <= w_size;
            r_cnt       <= w_cnt;
            r_sig       <= w_sig;
            r_sig_valid <= w_sig_valid;
            r_off       <= w_off;
            r_data      <= w_data;
            r_dvalid    <= w_dvalid;
            r_done      <= w_done;
            r_error     <= w_error;
            r_err       <= w_err;
        end
    end

    assign mem_req             = r_mem_req;
    assign mem_addr            = r_mem_addr;
    assign signature           = r_sig;
    assign signature_valid     = r_sig_valid;
    assign firmware_size       = r_size;
    assign firmware_addr       = r_off;
    assign firmware_data       = r_data;
    assign firmware_data_valid = r_dvalid;
    assign done                = r_done;
    assign error               = r_error;
    assign err_code            = r_err;

endmodule

// File: doc/firmware_image_reader.md
FIRMWARE_IMAGE_READER -- requirements
Module: firmware_image_reader

Interface
REQ-001 SHALL have parameter MAX_FW_BYTES, default 32'h0010_0000, the largest payload size accepted, in bytes.
REQ-002 SHALL have parameter IMG_MAGIC, default 32'h5346_5047, the required first header word.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, the read-response limit when FETCH_TIMEOUT_EN is defined.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk input 1, system clock, all state on rising edge; reset_n input 1, asynchronous active-low reset.
REQ-005 start  input  1  single-cycle pulse that begins an image read.
REQ-006 base_addr  input  32  image byte base address, sampled on an accepted start.
REQ-007 mem_req  output  1  single-cycle read request pulse.
REQ-008 mem_addr  output  32  byte address of the request, valid while mem_req is high.
REQ-009 mem_rdata  input  32  read data.
REQ-010 mem_rvalid  input  1  read data valid.
REQ-011 signature  output  256  captured image signature.
REQ-012 signature_valid  output  1  signature captured and size check passed.
REQ-013 firmware_size  output  32  payload size in bytes, from the header.
REQ-014 firmware_addr  output  32  payload byte offset of firmware_data.
REQ-015 firmware_data  output  32  payload word.
REQ-016 firmware_data_valid  output  1  payload word valid.
REQ-017 firmware_ready  input  1  consumer accepts the word.
REQ-018 done  output  1  payload fully delivered.
REQ-019 error  output  1  image rejected.
REQ-020 err_code  output  2  error cause: 1 bad magic, 2 bad size, 3 timeout.

Function
REQ-021 States SHALL be: IDLE, HDR_MAGIC, HDR_SIZE, HDR_SIG, STREAM, DONE, ERROR.
REQ-022 Image layout SHALL be: magic at base+0; size at base+4; signature words 0..7 at base+8..base+36; payload from base+40.
REQ-023 start SHALL be accepted only in IDLE, DONE or ERROR; it clears signature_valid, done, error and err_code, and mem_req SHALL pulse on the next cycle with mem_addr=base_addr.
REQ-024 At most one read SHALL be outstanding; the next mem_req SHALL be issued no earlier than the cycle after the previous word is consumed.
REQ-025 mem_rvalid with no read outstanding SHALL be ignored.
REQ-026 HDR_MAGIC: on a magic mismatch, the block SHALL enter ERROR with err_code=1.
REQ-027 HDR_SIZE: if size==0, size>MAX_FW_BYTES or size[1:0]!=0, the block SHALL enter ERROR with err_code=2; otherwise it latches firmware_size.
REQ-028 HDR_SIG: a 3-bit counter SHALL index the signature words; word 0 goes to signature[255:224] and word 7 to [31:0].
REQ-029 signature_valid SHALL rise the cycle after word 7 is captured and hold until the next start or reset.
REQ-030 STREAM: each response SHALL load firmware_data and assert firmware_data_valid the next cycle, with firmware_addr equal to the byte offset (0, 4, 8, ...).
REQ-031 Valid/ready: firmware_data_valid, firmware_data and firmware_addr SHALL hold stable until a cycle with firmware_ready high; the word is consumed on that cycle.
REQ-032 After the word at offset firmware_size-4 is consumed, the block SHALL enter DONE with done high; done holds until the next start.
REQ-033 ERROR and DONE SHALL be sticky; mem_req and firmware_data_valid SHALL stay low in both.
REQ-034 Offset arithmetic SHALL be 32-bit and mem_addr = base_addr + 40 + offset, modulo 2^32 (address wrap permitted).

Reset
REQ-035 On reset_n low, the block SHALL enter IDLE, and every output and internal counter SHALL be zero.
REQ-036 Reset mid-read SHALL abandon the read; a late mem_rvalid after release SHALL be ignored.

Configuration
REQ-037 FETCH_TIMEOUT_EN defined: a counter SHALL start at each mem_req; if it reaches TIMEOUT_CYCLES without mem_rvalid, the block enters ERROR with err_code=3.
REQ-038 FETCH_TIMEOUT_EN undefined: there SHALL be no counter, the block waits indefinitely, and err_code=3 never occurs.

Structure
REQ-039 A shared package SHALL hold the state enum, the err_code values, the header offsets (0, 4, 8, 40) and IMG_MAGIC.
REQ-040 The design SHALL be a single module; no sub-module.

Verification
REQ-041 Test: magic OK, size=8, signature words 0x1..0x8, firmware_ready=1 -> reads at base+0..+44; signature[255:224]=1 and [31:0]=8; two payload words at offsets 0 and 4; done.
REQ-042 Test: magic=0xDEADBEEF -> ERROR with err_code=1 after one read and no further mem_req.
REQ-043 Test: size=6, size=0 and size=MAX_FW_BYTES+4, one run each -> err_code=2 in each case and signature_valid stays 0.
REQ-044 Test: firmware_ready low for 5 cycles on word 0 -> data and address held, no new mem_req, advance only after firmware_ready rises.
REQ-045 Test: with FETCH_TIMEOUT_EN defined and no response -> err_code=3 after TIMEOUT_CYCLES.
REQ-046 Test: reset_n pulsed during HDR_SIG, then a stray mem_rvalid -> all outputs 0 and state stays IDLE.
